mmio_read_responder: RTL and testbench
======================================

// Module: mmio_read_responder
// PURPOSE
//   Read-return side of the MMIO bus. Takes a CPU load request, routes it by address[MSB:MSB-1]
//   (00 data memory, 01 LED, 10 switch, 11 unmapped) and returns the read data with a
//   valid/ready handshake. Absorbs data-memory read latency and synchronises the raw switch inputs.
//   Sits between the CPU load path and the data memory and IO registers.
// PARAMETERS
//   OPERAND_LENGTH  31            MSB index of address and data; bus width is OPERAND_LENGTH+1
//   MEM_LATENCY     1             cycles from mem_re to valid mem_rdata; legal range 1..15
//   LED_WIDTH       16            LED register width; must be <= OPERAND_LENGTH+1
//   SW_WIDTH        16            switch input width; must be <= OPERAND_LENGTH+1
//   ERR_VALUE       32'hDEADBEEF  data returned for an unmapped read
// PORTS
//   clk        in   1      single clock; all state updates on the rising edge
//   rst        in   1      asynchronous, active-high reset
//   req_valid  in   1      CPU read request valid
//   req_ready  out  1      responder can accept a request
//   req_addr   in   OPERAND_LENGTH+1  read address
//   mem_re     out  1      data-memory read strobe
//   mem_rdata  in   OPERAND_LENGTH+1  data-memory read data
//   led_state  in   LED_WIDTH  current LED register contents
//   switch_in  in   SW_WIDTH   raw asynchronous switch pins
//   rsp_valid  out  1      response valid
//   rsp_ready  in   1      CPU accepts the response
//   rsp_data   out  OPERAND_LENGTH+1  read data
//   rsp_err    out  1      response came from an unmapped address
// BEHAVIOUR
//   Reset (async): state=IDLE, rsp_valid=0, rsp_data=0, rsp_err=0, latency counter=0, switch
//     sync flops=0. mem_re=0 and req_ready=1 follow from IDLE.
//   Accept: a request is accepted on any edge where req_valid && req_ready.
//   req_ready=1 only in IDLE. At most one request is outstanding.
//   mem_re is combinational: req_valid & req_ready & (addr top==00). It is high only in the
//     request cycle.
//   switch_in passes through a 2-flop synchroniser, sw_sync. Reads return sw_sync as sampled
//     on the accept edge.
//   FSM:
//     IDLE --accept, top==00--> MEM_WAIT, cnt<=MEM_LATENCY-1
//     IDLE --accept, top==01--> RESP, rsp_data<=zext(led_state), rsp_err<=0
//     IDLE --accept, top==10--> RESP, rsp_data<=zext(sw_sync), rsp_err<=0
//     IDLE --accept, top==11--> RESP, rsp_data<=ERR_VALUE, rsp_err<=1
//     MEM_WAIT, cnt!=0 --> cnt<=cnt-1
//     MEM_WAIT, cnt==0 --> RESP, rsp_data<=mem_rdata, rsp_err<=0
//     RESP --rsp_ready--> IDLE, rsp_valid<=0
//     RESP, no rsp_ready --> stay; rsp_data and rsp_err held stable
//   rsp_valid=1 exactly while in RESP.
//   Latency, with the request accepted at edge k:
//     IO or unmapped read: rsp_valid rises after edge k.
//     Memory read: mem_rdata is sampled at edge k+MEM_LATENCY; rsp_valid rises after that edge.
//   No back-to-back accept: the earliest next accept is the edge after the rsp_ready handshake.
//   Zero-extension: LED and switch values are zero-extended into the upper bits of rsp_data.
//   Only address bits [MSB:MSB-1] are decoded; all lower bits are ignored.
//   Reset mid-operation: the outstanding request is dropped. Any mem_rdata arriving afterwards
//     is ignored and no response is issued.
//   req_valid asserted while not ready: ignored. The CPU must hold the request until it is accepted.
// TESTING
//   1 Reset with rst held high -> rsp_valid=0, rsp_data=0, req_ready=1, mem_re=0.
//   2 Memory read, MEM_LATENCY=2: req_addr=0x0000_0010 at edge k, memory model returns 0x1234_5678
//     -> mem_re high only in the request cycle; rsp_valid rises after k+2 with
//     rsp_data=0x1234_5678 and rsp_err=0.
//   3 LED read: led_state=16'hA5A5, addr 0x4000_0000 -> rsp_valid after k with
//     rsp_data=0x0000_A5A5; repeat with SW read: switch_in=16'h00FF held for >=2 cycles,
//     addr 0x8000_0004 -> rsp_data=0x0000_00FF.
//   4 Unmapped read: addr 0xC000_0000 -> rsp_data=0xDEADBEEF, rsp_err=1; next read clears rsp_err.
//   5 Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_data stable,
//     req_ready=0, a new req_valid is not accepted; rsp_ready=1 -> IDLE on the next edge.
//   6 Async rst pulse during MEM_WAIT -> immediate IDLE with rsp_valid=0; late mem_rdata ignored;
//     the next LED read completes normally.

Source files
------------

// File: rtl/mmio_read_responder.sv
// mmio_read_responder
//   Read-return side of the MMIO bus. Accepts one CPU load at a time and routes it
//   by the top two address bits: 00 data memory, 01 LED register, 10 switches,
//   11 unmapped. It waits out the data-memory latency, synchronises the raw switch
//   pins, and returns the read data on a valid/ready response channel.
//
//   State  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | ready for a request; mem_re may fire combinationally
//   MEM_WAIT | memory read in flight; cnt_q counts down to the sample edge
//   RESP   | response presented; held until rsp_ready
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      request handshake, req_addr read address
//   mem_re, mem_rdata        data-memory read strobe and returned data
//   led_state, switch_in     LED register contents, raw switch pins
//   rsp_valid/rsp_ready      response handshake, rsp_data / rsp_err payload
module mmio_read_responder #(
  parameter int                    OPERAND_LENGTH = 31,
  parameter int                    MEM_LATENCY    = 1,
  parameter int                    LED_WIDTH      = 16,
  parameter int                    SW_WIDTH       = 16,
  parameter logic [OPERAND_LENGTH:0] ERR_VALUE    = 32'hDEADBEEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [OPERAND_LENGTH:0] req_addr,
  output logic                    mem_re,
  input  logic [OPERAND_LENGTH:0] mem_rdata,
  input  logic [LED_WIDTH-1:0]    led_state,
  input  logic [SW_WIDTH-1:0]     switch_in,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [OPERAND_LENGTH:0] rsp_data,
  output logic                    rsp_err
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] RESP     = 2'd2;

  // Counter starts at LATENCY-1 on the accept edge so that the sample happens
  // exactly MEM_LATENCY edges after accept.
  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

  logic [1:0]              state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [OPERAND_LENGTH:0] rsp_data_q, rsp_data_d;
  logic                    rsp_err_q, rsp_err_d;
  logic [SW_WIDTH-1:0]     sw_meta_q, sw_meta_d;
  logic [SW_WIDTH-1:0]     sw_sync_q, sw_sync_d;

  logic [1:0] addr_top;
  logic       accept;
  logic       unused_addr;

  assign addr_top    = req_addr[OPERAND_LENGTH:OPERAND_LENGTH-1];
  assign unused_addr = ^req_addr[OPERAND_LENGTH-2:0];

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid & req_ready;
  assign mem_re    = accept & (addr_top == 2'b00);
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

  always_comb begin
    sw_meta_d  = switch_in;
    sw_sync_d  = sw_meta_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          case (addr_top)
            2'b00: begin
              state_d = MEM_WAIT;
              cnt_d   = CNT_INIT;
            end
            2'b01: begin
              state_d                     = RESP;
              rsp_data_d                  = '0;
              rsp_data_d[LED_WIDTH-1:0]   = led_state;
              rsp_err_d                   = 1'b0;
            end
            2'b10: begin
              state_d                     = RESP;
              rsp_data_d                  = '0;
              rsp_data_d[SW_WIDTH-1:0]    = sw_sync_q;
              rsp_err_d                   = 1'b0;
            end
            default: begin
              state_d    = RESP;
              rsp_data_d = ERR_VALUE;
              rsp_err_d  = 1'b1;
            end
          endcase
        end
      end
      MEM_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = RESP;
          rsp_data_d = mem_rdata;
          rsp_err_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      sw_meta_q  <= sw_meta_d;
      sw_sync_q  <= sw_sync_d;
    end
  end

endmodule

// File: tb/tb_mmio_read_responder.sv
// Bench for mmio_read_responder with MEM_LATENCY=2. A transaction-level model
// tracks the outstanding request and the expected response; a compare process
// checks the DUT against it on every falling edge, and directed transactions
// carry hand-computed expected values.
module tb_mmio_read_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        mem_re;
  logic [31:0] mem_rdata;
  logic [15:0] led_state;
  logic [15:0] switch_in;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;

  int checks   = 0;
  int failures = 0;

  mmio_read_responder #(.MEM_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .mem_re(mem_re), .mem_rdata(mem_rdata),
    .led_state(led_state), .switch_in(switch_in),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Memory: contents are a fixed function of the address; data appears LAT
  // edges after the strobe (pipeline not reset, so late data still shows up).
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0010) return 32'h1234_5678;
    return {a[15:0], ~a[15:0]};
  endfunction

  logic [31:0] mpipe0 = 32'hBAD0_BAD0;
  logic [31:0] mpipe1 = 32'hBAD0_BAD0;
  always @(posedge clk) begin
    mpipe0 <= mem_re ? mem_word(req_addr) : 32'hBAD0_BAD0;
    mpipe1 <= mpipe0;
  end
  assign mem_rdata = mpipe1;

  // Transaction model: busy while a request is outstanding, m_wait = edges left
  // until the memory sample, m_resp = response being presented.
  logic        m_busy, m_resp, m_err;
  logic [31:0] m_data;
  int          m_wait;
  logic [15:0] m_sw_meta, m_sw_sync;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0; m_resp <= 1'b0; m_err <= 1'b0; m_data <= 32'h0;
      m_wait <= 0; m_sw_meta <= 16'h0; m_sw_sync <= 16'h0;
    end else begin
      m_sw_meta <= switch_in;
      m_sw_sync <= m_sw_meta;
      if (m_resp && rsp_ready) begin
        m_resp <= 1'b0;
        m_busy <= 1'b0;
      end
      if (m_wait > 0) m_wait <= m_wait - 1;
      if (m_wait == 1) begin
        m_resp <= 1'b1; m_data <= mem_rdata; m_err <= 1'b0;
      end
      if (req_valid && !m_busy) begin
        m_busy <= 1'b1;
        case (req_addr[31:30])
          2'b00: m_wait <= LAT;
          2'b01: begin m_resp <= 1'b1; m_data <= {16'h0, led_state}; m_err <= 1'b0; end
          2'b10: begin m_resp <= 1'b1; m_data <= {16'h0, m_sw_sync}; m_err <= 1'b0; end
          default: begin m_resp <= 1'b1; m_data <= 32'hDEADBEEF; m_err <= 1'b1; end
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("cmp_req_ready", {31'b0, req_ready}, {31'b0, !m_busy});
      chk("cmp_rsp_valid", {31'b0, rsp_valid}, {31'b0, m_resp});
      chk("cmp_mem_re", {31'b0, mem_re},
          {31'b0, req_valid && !m_busy && (req_addr[31:30] == 2'b00)});
      if (m_resp) begin
        chk("cmp_rsp_data", rsp_data, m_data);
        chk("cmp_rsp_err", {31'b0, rsp_err}, {31'b0, m_err});
      end
    end
  end

  // Issue one read starting just after a rising edge; check latency, payload,
  // optional backpressure hold, and the return to idle.
  task automatic read_txn(input string name, input logic [31:0] addr, input int exp_lat,
                          input logic [31:0] exp_data, input logic exp_err, input int hold);
    int n;
    req_addr  = addr;
    req_valid = 1'b1;
    #1;
    chk({name, "_mem_re_req"}, {31'b0, mem_re}, {31'b0, addr[31:30] == 2'b00});
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk({name, "_mem_re_after"}, {31'b0, mem_re}, 32'h0);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_latency"}, n, exp_lat);
    chk({name, "_data"}, rsp_data, exp_data);
    chk({name, "_err"}, {31'b0, rsp_err}, {31'b0, exp_err});
    if (hold > 0) begin
      req_valid = 1'b1;
      req_addr  = 32'h4000_0000;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        chk({name, "_hold_valid"}, {31'b0, rsp_valid}, 32'h1);
        chk({name, "_hold_data"}, rsp_data, exp_data);
        chk({name, "_hold_ready"}, {31'b0, req_ready}, 32'h0);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    chk({name, "_done_valid"}, {31'b0, rsp_valid}, 32'h0);
    chk({name, "_done_ready"}, {31'b0, req_ready}, 32'h1);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = 32'h0; led_state = 16'h0;
    switch_in = 16'h0; rsp_ready = 1'b0;

    #12;
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_req_ready", {31'b0, req_ready}, 32'h1);
    chk("rst_mem_re", {31'b0, mem_re}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    read_txn("mem", 32'h0000_0010, 2, 32'h1234_5678, 1'b0, 0);
    read_txn("mem_lowbits", 32'h3FFF_FFF0, 2, 32'hFFF0_000F, 1'b0, 0);

    led_state = 16'hA5A5;
    read_txn("led", 32'h4000_0000, 0, 32'h0000_A5A5, 1'b0, 0);

    switch_in = 16'h00FF;
    repeat (3) @(posedge clk);
    #1;
    read_txn("sw", 32'h8000_0004, 0, 32'h0000_00FF, 1'b0, 0);
    // A fresh switch value needs two edges to reach the synchroniser output.
    switch_in = 16'h0F0F;
    read_txn("sw_sync_delay", 32'h8000_0000, 0, 32'h0000_00FF, 1'b0, 0);
    read_txn("sw_new", 32'h8000_0000, 0, 32'h0000_0F0F, 1'b0, 0);

    read_txn("unmapped", 32'hC000_0000, 0, 32'hDEADBEEF, 1'b1, 0);
    read_txn("clr_err", 32'h4000_0000, 0, 32'h0000_A5A5, 1'b0, 0);

    led_state = 16'h5A5A;
    read_txn("backpressure", 32'h4000_0008, 0, 32'h0000_5A5A, 1'b0, 5);
    read_txn("mem_bp", 32'h0000_0010, 2, 32'h1234_5678, 1'b0, 3);

    // Reset in the middle of a memory wait.
    req_addr = 32'h0000_0020;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    #3 rst = 1'b1;
    #1;
    chk("midrst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("midrst_req_ready", {31'b0, req_ready}, 32'h1);
    chk("midrst_rsp_data", rsp_data, 32'h0);
    #2 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_rsp", {31'b0, rsp_valid}, 32'h0);
    end
    led_state = 16'h1234;
    read_txn("after_rst_led", 32'h4000_0000, 0, 32'h0000_1234, 1'b0, 0);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
